// File: rtl/display_pkg.sv
// Shared types and helpers for the display scan path.
package display_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 16;
  localparam int BUS_W      = BCD_W * MAX_DIGITS;

  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    SCAN_BLANK,
    SCAN_SHOW
  } scan_state_e;

  // Extract BCD nibble idx from a zero-extended packed digit bus.
  function automatic logic [BCD_W-1:0] nibble_at(input logic [BUS_W-1:0] bus,
                                                 input int unsigned idx);
    return bus[idx*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_slot_timer.sv
// Slot/digit counters for the scan multiplexer.
// slot_count runs 0..SLOT_CYCLES-1; each wrap advances digit_idx, which
// wraps after the last digit. frame_strobe marks the first cycle of a frame.
module scan_slot_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 50000,
  parameter int CNT_W       = $clog2(SLOT_CYCLES),
  parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] slot_count,
  output logic [IDX_W-1:0] digit_idx,
  output logic             frame_strobe
);

  logic slot_wrap;
  logic last_digit;

  assign slot_wrap    = (slot_count == CNT_W'(SLOT_CYCLES - 1));
  assign last_digit   = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_strobe = (slot_count == '0) && (digit_idx == '0);

  // Advance the slot counter every cycle and the digit index on slot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_count <= '0;
      digit_idx  <= '0;
    end else begin
      if (slot_wrap) begin
        slot_count <= '0;
        digit_idx  <= last_digit ? '0 : digit_idx + IDX_W'(1);
      end else begin
        slot_count <= slot_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with per-slot blanking gap and
// per-frame digit snapshot. Optional leading-zero blanking is enabled by
// defining DISPLAY_SCAN_LZB_EN.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BCD_W*NUM_DIGITS-1:0]   digits,
  output logic [BCD_W-1:0]              bcdOut,
  output logic [NUM_DIGITS-1:0]         digitEnable,
  output logic                          frameStart
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]              slot_count;
  logic [IDX_W-1:0]              digit_idx;
  logic                          frame_strobe;
  logic [BCD_W*NUM_DIGITS-1:0]   snapshot;
  logic [BUS_W-1:0]              snap_wide;
  logic [NUM_DIGITS-1:0]         suppress;
  scan_state_e                   state;

  scan_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .CNT_W       (CNT_W),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .slot_count   (slot_count),
    .digit_idx    (digit_idx),
    .frame_strobe (frame_strobe)
  );

  assign snap_wide = BUS_W'(snapshot);
  assign state     = (slot_count < CNT_W'(BLANK_CYCLES)) ? SCAN_BLANK : SCAN_SHOW;

`ifdef DISPLAY_SCAN_LZB_EN
  // Suppress digit i>0 when it and every higher snapshot digit are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero && (nibble_at(snap_wide, i) == '0);
      suppress[i] = (i != 0) && all_zero;
    end
  end
`else
  assign suppress = '0;
`endif

  // Capture the digit snapshot at frame start and register the scan outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot    <= '0;
      bcdOut      <= BCD_BLANK;
      digitEnable <= '1;
      frameStart  <= 1'b0;
    end else begin
      frameStart <= frame_strobe;
      if (frame_strobe) begin
        snapshot <= digits;
      end
      if (state == SCAN_SHOW && !suppress[digit_idx]) begin
        digitEnable <= ~(NUM_DIGITS'(1) << digit_idx);
        bcdOut      <= nibble_at(snap_wide, 32'(digit_idx));
      end else begin
        digitEnable <= '1;
        bcdOut      <= BCD_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed table-driven bench for display_scan_mux (4 digits, 8-cycle slots,
// 2-cycle blank). Expected values are hand-derived from the scan timing.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  bcdOut;
  logic [3:0]  digitEnable;
  logic        frameStart;

  int tests  = 0;
  int failed = 0;
  int edge_n = 0;
  logic [3:0] prev_en = 4'b1111;

  typedef struct {
    int         edge_no;
    logic [3:0] en;
    logic [3:0] bcd;
    logic       fs;
  } vec_t;

  vec_t vecs[$];

  display_scan_mux #(
    .NUM_DIGITS   (4),
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .bcdOut      (bcdOut),
    .digitEnable (digitEnable),
    .frameStart  (frameStart)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] en,
                       input logic [3:0] bcd, input logic fs);
    tests++;
    if (digitEnable !== en || bcdOut !== bcd || frameStart !== fs) begin
      failed++;
      $display("FAIL %s edge %0d: got en=%b bcd=%h fs=%b, want en=%b bcd=%h fs=%b",
               name, edge_n, digitEnable, bcdOut, frameStart, en, bcd, fs);
    end
  endtask

  // One clock edge, then sample and check the enable invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    tests++;
    if (!(digitEnable == 4'b1111 || digitEnable == 4'b1110 || digitEnable == 4'b1101 ||
          digitEnable == 4'b1011 || digitEnable == 4'b0111)) begin
      failed++;
      $display("FAIL onehot edge %0d: got en=%b, want one-hot-low or 1111", edge_n, digitEnable);
    end
    if (prev_en != 4'b1111 && digitEnable != 4'b1111 && digitEnable != prev_en) begin
      failed++;
      $display("FAIL gap edge %0d: got en %b -> %b, want an all-off cycle between", edge_n, prev_en, digitEnable);
    end
    prev_en = digitEnable;
  endtask

  task automatic do_reset(input int n, input string name);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, 4'b1111, 4'hF, 1'b0);
    end
    reset  = 1'b0;
    edge_n = 0;
  endtask

  // Walk the vector table up to last_edge; digits switch to 5678 after edge 12.
  task automatic run_table(input int last_edge, input string name);
    digits = 16'h1234;
    foreach (vecs[k]) begin
      if (vecs[k].edge_no > last_edge) break;
      while (edge_n < vecs[k].edge_no) begin
        tick();
        if (edge_n == 12) digits = 16'h5678;
      end
      check(name, vecs[k].en, vecs[k].bcd, vecs[k].fs);
    end
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  initial begin
    vecs.push_back('{1,  4'b1111, 4'hF, 1'b1});
    vecs.push_back('{2,  4'b1111, 4'hF, 1'b0});
    vecs.push_back('{3,  4'b1110, 4'h4, 1'b0});
    vecs.push_back('{8,  4'b1110, 4'h4, 1'b0});
    vecs.push_back('{9,  4'b1111, 4'hF, 1'b0});
    vecs.push_back('{10, 4'b1111, 4'hF, 1'b0});
    vecs.push_back('{11, 4'b1101, 4'h3, 1'b0});
    vecs.push_back('{16, 4'b1101, 4'h3, 1'b0});
    vecs.push_back('{17, 4'b1111, 4'hF, 1'b0});
    vecs.push_back('{19, 4'b1011, 4'h2, 1'b0});
    vecs.push_back('{24, 4'b1011, 4'h2, 1'b0});
    vecs.push_back('{26, 4'b1111, 4'hF, 1'b0});
    vecs.push_back('{27, 4'b0111, 4'h1, 1'b0});
    vecs.push_back('{32, 4'b0111, 4'h1, 1'b0});
    vecs.push_back('{33, 4'b1111, 4'hF, 1'b1});
    vecs.push_back('{34, 4'b1111, 4'hF, 1'b0});
    vecs.push_back('{35, 4'b1110, 4'h8, 1'b0});
    vecs.push_back('{43, 4'b1101, 4'h7, 1'b0});
    vecs.push_back('{51, 4'b1011, 4'h6, 1'b0});
    vecs.push_back('{59, 4'b0111, 4'h5, 1'b0});
    vecs.push_back('{65, 4'b1111, 4'hF, 1'b1});

    reset  = 1'b1;
    digits = 16'h1234;
    #1;

    // Reset held for three edges, then the full two-frame sequence.
    do_reset(3, "reset");
    run_table(65, "scan");

    // Reset mid-slot at edge 13 while digit 1 is shown.
    do_reset(1, "pre");
    digits = 16'h1234;
    run_to(12);
    reset = 1'b1;
    tick();
    check("midreset", 4'b1111, 4'hF, 1'b0);
    reset  = 1'b0;
    edge_n = 0;
    run_table(32, "replay");

    // Leading zeros: 0007.
    digits = 16'h0007;
    do_reset(1, "lzb_rst");
    run_to(3);  check("lzb7_d0", 4'b1110, 4'h7, 1'b0);
`ifdef DISPLAY_SCAN_LZB_EN
    run_to(11); check("lzb7_d1", 4'b1111, 4'hF, 1'b0);
    run_to(19); check("lzb7_d2", 4'b1111, 4'hF, 1'b0);
    run_to(27); check("lzb7_d3", 4'b1111, 4'hF, 1'b0);
`else
    run_to(11); check("lzb7_d1", 4'b1101, 4'h0, 1'b0);
    run_to(19); check("lzb7_d2", 4'b1011, 4'h0, 1'b0);
    run_to(27); check("lzb7_d3", 4'b0111, 4'h0, 1'b0);
`endif

    // All zeros.
    digits = 16'h0000;
    do_reset(1, "zero_rst");
    run_to(3);  check("zero_d0", 4'b1110, 4'h0, 1'b0);
`ifdef DISPLAY_SCAN_LZB_EN
    run_to(11); check("zero_d1", 4'b1111, 4'hF, 1'b0);
    run_to(27); check("zero_d3", 4'b1111, 4'hF, 1'b0);
`else
    run_to(11); check("zero_d1", 4'b1101, 4'h0, 1'b0);
    run_to(27); check("zero_d3", 4'b0111, 4'h0, 1'b0);
`endif

    // Non-BCD nibble passes through unchanged.
    digits = 16'h00A0;
    do_reset(1, "hex_rst");
    run_to(3);  check("hex_d0", 4'b1110, 4'h0, 1'b0);
    run_to(11); check("hex_d1", 4'b1101, 4'hA, 1'b0);
`ifdef DISPLAY_SCAN_LZB_EN
    run_to(19); check("hex_d2", 4'b1111, 4'hF, 1'b0);
`else
    run_to(19); check("hex_d2", 4'b1011, 4'h0, 1'b0);
`endif
    run_to(40);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
